// File: rtl/uart_pkg.sv
// Shared types and helpers for the FIFO-fed UART transmitter.
// Frame sequencing states and baud divisor arithmetic live here.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WAIT,
    LOAD,
    START,
    DATA,
    STOP
  } state_e;

  function automatic int baud_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  localparam int DEF_BAUD_DIV = baud_div(50_000_000, 115200);
  localparam int DEF_CNT_W    = $clog2(DEF_BAUD_DIV);

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..DIV-1, ticks on the wrap cycle.
// A synchronous clear realigns the bit phase to a new frame.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int DIV = DEF_BAUD_DIV,
  parameter int CW  = DEF_CNT_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  output logic [CW-1:0] cnt_o,
  output logic          tick_o
);

  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr_i || cnt_q == LAST) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/uart_fifo_tx.sv
// Pulls bytes from a non-show-ahead FIFO and sends them as 8N1 frames.
// All outputs are registered from next-state values.
module uart_fifo_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200,
  parameter int BAUD_DIV = baud_div(CLK_FREQ, BAUD)
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tx_en,
  input  logic       fifo_empty,
  output logic       fifo_rdreq,
  input  logic [7:0] fifo_q,
  output logic       uart_tx,
  output logic       tx_busy,
  output logic       byte_done
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] PRE_LAST = CW'(BAUD_DIV - 2);

  state_e        state_q, state_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          rd_q, rd_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [CW-1:0] cnt;
  logic          tick;
  logic          clr;

  assign clr = (state_q == LOAD);

  uart_baud_gen #(
    .DIV (BAUD_DIV),
    .CW  (CW)
  ) u_baud (
    .clk    (clk),
    .rst_n  (reset_n),
    .clr_i  (clr),
    .cnt_o  (cnt),
    .tick_o (tick)
  );

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    unique case (state_q)
      IDLE:  if (tx_en && !fifo_empty) state_d = RD;
      RD:    state_d = WAIT;
      WAIT:  state_d = LOAD;
      LOAD: begin
        shift_d = fifo_q;
        state_d = START;
      end
      START: if (tick) begin
        state_d = DATA;
        bit_d   = 3'd0;
      end
      DATA: if (tick) begin
        if (bit_q == 3'd7) state_d = STOP;
        else               bit_d   = bit_q + 3'd1;
      end
      STOP:  if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registers line up
  // with the state they describe.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[bit_d];
      default: tx_d = 1'b1;
    endcase
    rd_d   = (state_d == RD);
    busy_d = (state_d != IDLE);
    done_d = (state_q == STOP) && (cnt == PRE_LAST);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      rd_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      rd_q    <= rd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign uart_tx    = tx_q;
  assign fifo_rdreq = rd_q;
  assign tx_busy    = busy_q;
  assign byte_done  = done_q;

endmodule
